// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Turns a stream of PS/2 set-2 scan bytes into per-key held state for a small
//   table of keys. It also produces a frame-rate "move" code naming the
//   lowest-indexed held key.
//
// Ports
//   CLOCK_50        in   system clock, all logic on the rising edge
//   resetn          in   synchronous active-low reset
//   scan_done_tick  in   one-cycle strobe, scan_code carries a new byte
//   scan_code[7:0]  in   received PS/2 byte
//   frame_tick      in   one-cycle strobe at frame rate
//   key_held        out  current held state per tracked key
//   key_pressed     out  one-cycle pulse on a released-to-held transition
//   move            out  frame-latched code: lowest held index + 1, or 0
//   move_valid      out  one-cycle pulse while a freshly loaded move is visible
module ps2_key_tracker #(
    parameter int                    NUM_KEYS    = 5,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES   = {9'h029, 9'h023, 9'h01B, 9'h01C, 9'h01D},
    parameter int                    MOVE_W      = 3,
    parameter int                    TIMEOUT_CYC = 1000000
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                scan_done_tick,
    input  logic [7:0]          scan_code,
    input  logic                frame_tick,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_pressed,
    output logic [MOVE_W-1:0]   move,
    output logic                move_valid
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               ev_vld;
    logic               ev_ext;
    logic               ev_brk;
    logic [NUM_KEYS-1:0] held_next;
    logic [MOVE_W-1:0]  move_calc;

    // Keyboard self-test / ack / resend / echo / error bytes never start a key event.
    function automatic logic is_filler(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
               (b == 8'hEE) || (b == 8'h00);
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Prefix decoder: E0 always restarts an extended sequence, a repeated F0
    // after a break prefix is harmless, any other byte terminates the sequence.
    always_comb begin
        state_next = state;
        ev_vld     = 1'b0;
        ev_ext     = 1'b0;
        ev_brk     = 1'b0;
        if (scan_done_tick) begin
            if (scan_code == 8'hE0) begin
                state_next = EXT;
            end else if (scan_code == 8'hF0) begin
                case (state)
                    IDLE:    state_next = BRK;
                    EXT:     state_next = EXT_BRK;
                    default: state_next = state;
                endcase
            end else begin
                state_next = IDLE;
                ev_ext     = (state == EXT) || (state == EXT_BRK);
                ev_brk     = (state == BRK) || (state == EXT_BRK);
                ev_vld     = !((state == IDLE) && is_filler(scan_code));
            end
        end else if ((state != IDLE) && (tmo_cnt == CNT_MAX)) begin
            // A prefix that never got its final byte is abandoned silently.
            state_next = IDLE;
        end
    end

    always_comb begin
        held_next = key_held;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (ev_vld && (KEY_CODES[i*9 +: 9] == {ev_ext, scan_code})) begin
                held_next[i] = !ev_brk;
            end
        end
    end

    // Scanning downward lets the lowest held index win.
    always_comb begin
        move_calc = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_held[i]) begin
                move_calc = MOVE_W'(i + 1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            tmo_cnt     <= '0;
            key_held    <= '0;
            key_pressed <= '0;
            move        <= '0;
            move_valid  <= 1'b0;
        end else begin
            if (scan_done_tick) begin
                tmo_cnt <= '0;
            end else if ((state != IDLE) && (tmo_cnt != CNT_MAX)) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            key_held    <= held_next;
            key_pressed <= held_next & ~key_held;
            // move_calc reads the registered key_held, so a coincident key
            // update is seen only on the next frame.
            if (frame_tick) begin
                move <= move_calc;
            end
            move_valid <= frame_tick;
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker
//   Directed and randomized byte streams for ps2_key_tracker. Every cycle the
//   outputs are compared with a behavioural model that tracks the pending
//   prefix as two flags and looks events up in a key table.
module tb_ps2_key_tracker;

    localparam int NK = 6;
    localparam int MW = 3;
    localparam int TO = 40;
    localparam logic [NK*9-1:0] KC = {9'h175, 9'h029, 9'h023, 9'h01B, 9'h01C, 9'h01D};

    logic          CLOCK_50;
    logic          resetn;
    logic          scan_done_tick;
    logic [7:0]    scan_code;
    logic          frame_tick;
    logic [NK-1:0] key_held;
    logic [NK-1:0] key_pressed;
    logic [MW-1:0] move;
    logic          move_valid;

    ps2_key_tracker #(
        .NUM_KEYS    (NK),
        .KEY_CODES   (KC),
        .MOVE_W      (MW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .resetn         (resetn),
        .scan_done_tick (scan_done_tick),
        .scan_code      (scan_code),
        .frame_tick     (frame_tick),
        .key_held       (key_held),
        .key_pressed    (key_pressed),
        .move           (move),
        .move_valid     (move_valid)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Reference model state
    logic [8:0]    tbl [NK] = '{9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h029, 9'h175};
    logic [NK-1:0] m_held;
    logic [NK-1:0] m_pressed;
    logic [MW-1:0] m_move;
    logic          m_valid;
    bit            pend_ext;
    bit            pend_brk;
    int            quiet_cnt;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [MW-1:0] lowest_move(input logic [NK-1:0] h);
        for (int i = 0; i < NK; i++) begin
            if (h[i]) return MW'(i + 1);
        end
        return '0;
    endfunction

    task automatic model_edge(input logic rst_n, input logic tick,
                              input logic [7:0] code, input logic frm);
        logic [NK-1:0] old_held;
        bit            is_junk;
        if (!rst_n) begin
            m_held = '0; m_pressed = '0; m_move = '0; m_valid = 1'b0;
            pend_ext = 0; pend_brk = 0; quiet_cnt = 0;
            return;
        end
        old_held  = m_held;
        m_pressed = '0;
        if (frm) m_move = lowest_move(old_held);
        m_valid = frm;
        if (tick) begin
            quiet_cnt = 0;
            is_junk = (code == 8'hAA) || (code == 8'hFA) || (code == 8'hFE) ||
                      (code == 8'hEE) || (code == 8'h00);
            if (code == 8'hE0) begin
                pend_ext = 1; pend_brk = 0;
            end else if (code == 8'hF0) begin
                pend_brk = 1;
            end else begin
                if (pend_ext || pend_brk || !is_junk) begin
                    for (int i = 0; i < NK; i++) begin
                        if (tbl[i] == {pend_ext ? 1'b1 : 1'b0, code}) begin
                            if (pend_brk) begin
                                m_held[i] = 1'b0;
                            end else begin
                                if (!old_held[i]) m_pressed[i] = 1'b1;
                                m_held[i] = 1'b1;
                            end
                        end
                    end
                end
                pend_ext = 0; pend_brk = 0;
            end
        end else if (pend_ext || pend_brk) begin
            quiet_cnt++;
            if (quiet_cnt >= TO) begin
                pend_ext = 0; pend_brk = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst_n, input logic tick,
                        input logic [7:0] code, input logic frm);
        @(negedge CLOCK_50);
        resetn         = rst_n;
        scan_done_tick = tick;
        scan_code      = code;
        frame_tick     = frm;
        @(posedge CLOCK_50);
        model_edge(rst_n, tick, code, frm);
        #1;
        chk("key_held",    32'(key_held),    32'(m_held));
        chk("key_pressed", 32'(key_pressed), 32'(m_pressed));
        chk("move",        32'(move),        32'(m_move));
        chk("move_valid",  32'(move_valid),  32'(m_valid));
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, 1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic frame();
        step(1'b1, 1'b0, 8'h00, 1'b1);
    endtask

    logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h1D, 8'h1C, 8'h1B, 8'h23,
                             8'h29, 8'h75, 8'hAA, 8'h00, 8'hF0, 8'hE0};

    initial begin
        resetn = 1'b0; scan_done_tick = 1'b0; scan_code = 8'h00; frame_tick = 1'b0;
        m_held = '0; m_pressed = '0; m_move = '0; m_valid = 1'b0;
        pend_ext = 0; pend_brk = 0; quiet_cnt = 0;

        // Reset state
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h1D, 1'b1);
        chk("reset_held", 32'(key_held), 32'd0);
        idle(2);

        // Make / break of key 0
        send(8'h1D);
        chk("make_held", 32'(key_held), 32'd1);
        chk("make_pulse", 32'(key_pressed), 32'd1);
        frame();
        chk("make_move", 32'(move), 32'd1);
        idle(1);
        send(8'hF0); send(8'h1D);
        chk("break_held", 32'(key_held), 32'd0);
        frame();
        chk("break_move", 32'(move), 32'd0);
        idle(2);

        // Priority and typematic repeat
        send(8'h23); send(8'h1C); send(8'h23); send(8'h23);
        frame(); idle(1);
        send(8'hF0); send(8'h23); send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h29);

        // Extended key
        send(8'h75);
        send(8'hE0); send(8'h75);
        chk("ext_make", 32'(key_held[5]), 32'd1);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("ext_break", 32'(key_held[5]), 32'd0);

        // Filler bytes and prefix restarts
        send(8'hAA); send(8'hFA); send(8'hF0); send(8'hF0); send(8'h1B);
        send(8'hF0); send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0);
        send(8'hF0); send(8'h75);

        // Abandoned break prefix
        send(8'hF0);
        idle(TO + 3);
        send(8'h1D);
        chk("timeout_make", 32'(key_held[0]), 32'd1);
        // Prefix survives a gap shorter than the timeout
        send(8'hF0); idle(TO - 5); send(8'h1D);
        chk("short_gap_break", 32'(key_held[0]), 32'd0);

        // Collision of byte and frame tick
        frame();
        step(1'b1, 1'b1, 8'h1D, 1'b1);
        chk("collide_move", 32'(move), 32'd0);
        chk("collide_held", 32'(key_held[0]), 32'd1);
        frame();

        // Reset after a bare prefix, then reset racing a byte
        send(8'hF0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("mid_reset_move", 32'(move), 32'd0);
        send(8'h1D);
        chk("post_reset_make", 32'(key_held[0]), 32'd1);
        step(1'b0, 1'b1, 8'h1C, 1'b1);
        idle(1);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                step(1'b0, $urandom_range(0, 1) == 1, pool[$urandom_range(0, 11)],
                     $urandom_range(0, 1) == 1);
            end else if (r < 3) begin
                idle(TO - 3 + int'($urandom_range(0, 6)));
            end else if (r < 110) begin
                logic [7:0] b;
                b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
                step(1'b1, 1'b1, b, $urandom_range(0, 7) == 0);
            end else begin
                step(1'b1, 1'b0, 8'($urandom), $urandom_range(0, 5) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
